// File: rtl/l2_vec_sender.sv
// Vector source and result collector for the L2-norm streaming datapath.
// Optional feature macro: L2_BUBBLE_EN (LFSR-driven bubble cycles while sending).
module l2_vec_sender #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       start,
  output logic       busy,
  output logic [7:0] a,
  output logic       valid_out,
  input  logic [9:0] g,
  input  logic       valid_in,
  output logic [9:0] result,
  output logic       done,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t          r_state,  w_state;
  logic [CW-1:0]   r_count,  w_count;
  logic [AW-1:0]   r_wr_ptr, w_wr_ptr;
  logic [AW-1:0]   r_rd_ptr, w_rd_ptr;
  logic [CW-1:0]   r_sent,   w_sent;
  logic [CW-1:0]   r_rcvd,   w_rcvd;
  logic [TW-1:0]   r_timer,  w_timer;
  logic            r_full,   w_full;
  logic            r_busy,   w_busy;
  logic [7:0]      r_a,      w_a;
  logic            r_valid_out, w_valid_out;
  logic [9:0]      r_result, w_result;
  logic            r_done,   w_done;
  logic            r_err,    w_err;
  logic            w_wr_ok;
  logic            w_bubble;
  logic [7:0]      w_rd_data;
  logic [7:0]      r_buf [DEPTH];

`ifdef L2_BUBBLE_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; the low bit decides whether a SEND cycle idles.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_bubble = r_lfsr[0];
`else
  assign w_bubble = 1'b0;
`endif

  assign w_rd_data = r_buf[r_rd_ptr];

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_wr_ptr    = r_wr_ptr;
    w_rd_ptr    = r_rd_ptr;
    w_sent      = r_sent;
    w_rcvd      = r_rcvd;
    w_timer     = r_timer;
    w_a         = r_a;
    w_valid_out = 1'b0;
    w_result    = r_result;
    w_done      = 1'b0;
    w_err       = r_err;
    w_wr_ok     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (wr_en && (r_count != CW'(DEPTH))) begin
          w_wr_ok  = 1'b1;
          w_wr_ptr = r_wr_ptr + AW'(1);
          w_count  = r_count + CW'(1);
        end
        // start looks at the count including a write landing this same cycle
        if (start && (w_count != '0)) begin
          w_state  = S_SEND;
          w_rd_ptr = '0;
          w_sent   = '0;
          w_rcvd   = '0;
          w_err    = 1'b0;
        end
      end

      S_SEND: begin
        if (valid_in) begin
          w_result = g;
          w_rcvd   = r_rcvd + CW'(1);
        end
        if (!w_bubble) begin
          w_a         = w_rd_data;
          w_valid_out = 1'b1;
          w_rd_ptr    = r_rd_ptr + AW'(1);
          w_sent      = r_sent + CW'(1);
          if (w_sent == r_count) begin
            w_state = S_DRAIN;
            w_timer = TW'(TIMEOUT);
          end
        end
      end

      S_DRAIN: begin
        if (valid_in) begin
          w_result = g;
          w_rcvd   = r_rcvd + CW'(1);
          w_timer  = TW'(TIMEOUT);
        end
        if (w_rcvd == r_count) begin
          w_done   = 1'b1;
          w_count  = '0;
          w_wr_ptr = '0;
          w_state  = S_IDLE;
        end else if (!valid_in) begin
          if (r_timer <= TW'(1)) begin
            w_err   = 1'b1;
            w_count = '0;
            w_state = S_IDLE;
          end else begin
            w_timer = r_timer - TW'(1);
          end
        end
      end

      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
    w_full = (w_count == CW'(DEPTH));
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sent      <= '0;
      r_rcvd      <= '0;
      r_timer     <= '0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_valid_out <= 1'b0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_wr_ptr    <= w_wr_ptr;
      r_rd_ptr    <= w_rd_ptr;
      r_sent      <= w_sent;
      r_rcvd      <= w_rcvd;
      r_timer     <= w_timer;
      r_full      <= w_full;
      r_busy      <= w_busy;
      r_a         <= w_a;
      r_valid_out <= w_valid_out;
      r_result    <= w_result;
      r_done      <= w_done;
      r_err       <= w_err;
    end
  end

  // NOTE: the element buffer has no reset; count and pointers make stale
  // entries unreachable, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !reset) r_buf[r_wr_ptr] <= wr_data;
  end

  assign full      = r_full;
  assign busy      = r_busy;
  assign a         = r_a;
  assign valid_out = r_valid_out;
  assign result    = r_result;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_l2_vec_sender.sv
// Self-checking bench for l2_vec_sender with a 2-cycle running-norm model
// and a scoreboard of expected elements on the a/valid_out stream.
module tb_l2_vec_sender;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full;
  logic       start = 1'b0;
  logic       busy;
  logic [7:0] a;
  logic       valid_out;
  logic [9:0] g = '0;
  logic       valid_in = 1'b0;
  logic [9:0] result;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int  tb_count = 0;
  bit  mon_en = 1'b1;
  bit  model_en = 1'b1;
  int unsigned model_sum = 0;
  logic        p_v = 1'b0;
  logic [9:0]  p_g = '0;
  int  vout_cnt = 0;
  int  done_cnt = 0;
  int  bubble_total = 0;

  l2_vec_sender #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .start(start), .busy(busy), .a(a), .valid_out(valid_out), .g(g),
    .valid_in(valid_in), .result(result), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int unsigned isqrt(int unsigned n);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Norm unit model: a sampled at one edge returns as g two edges later.
  always @(negedge clk) begin
    valid_in = p_v;
    g        = p_g;
    p_v      = 1'b0;
    if (valid_out && model_en) begin
      model_sum = model_sum + a * a;
      p_v = 1'b1;
      p_g = 10'(isqrt(model_sum));
    end
  end

  // Stream monitor: every issued element must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (valid_out) begin
      vout_cnt++;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: got a=%0d, expected no element", a);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL stream_order: got a=%0d, expected %0d", a, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_elem(input logic [7:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    if (tb_count < DEPTH) begin
      exp_q.push_back(v);
      tb_count++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({full, busy, a, valid_out, result, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got full=%b busy=%b a=%0d vo=%b result=%0d done=%b err=%b, expected all 0",
               full, busy, a, valid_out, result, done, err);
    end
    reset = 1'b0;
    tick();
    tb_count = 0;
  endtask

  task automatic test_happy();
    int first_v = -1, last_v = -1, done_at = -1, d0;
    logic prev_vin = 1'b0;
    logic [9:0] prev_g = '0;
    model_sum = 0;
    vout_cnt  = 0;
    write_elem(8'd21);
    write_elem(8'd36);
    write_elem(8'd64);
    d0 = done_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL happy_busy: got busy=%b, expected 1", busy);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev_vin) begin
        checks++;
        if (result !== prev_g) begin
          failures++;
          $display("FAIL happy_result_track: got result=%0d, expected %0d", result, prev_g);
        end
      end
      prev_vin = valid_in;
      prev_g   = g;
      if (valid_out) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (done) begin done_at = i; break; end
    end
    checks++;
    if (done_at < 0) begin
      failures++;
      $display("FAIL happy_done: no done within 40 cycles, expected done");
    end else begin
      checks++;
      if ({busy, result, full, err} !== {1'b0, 10'd76, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL happy_final: got busy=%b result=%0d full=%b err=%b, expected 0/76/0/0",
                 busy, result, full, err);
      end
    end
    checks++;
    if (vout_cnt != 3) begin
      failures++;
      $display("FAIL happy_count: got %0d elements, expected 3", vout_cnt);
    end
`ifdef L2_BUBBLE_EN
    bubble_total += (last_v + 1) - 3;
`else
    checks++;
    if (first_v != 0 || last_v != 2) begin
      failures++;
      $display("FAIL happy_timing: got valid cycles %0d..%0d, expected 0..2", first_v, last_v);
    end
`endif
    tick();
    tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL happy_done_once: got %0d done pulses, expected 1", done_cnt - d0);
    end
    tb_count = 0;
  endtask

  task automatic test_empty_start();
    logic bad = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bad |= busy | valid_out | done;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL empty_start: got activity=%b, expected 0", bad);
    end
  endtask

  task automatic test_full();
    int ok, last_v = -1;
    model_sum = 0;
    vout_cnt  = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      write_elem(8'(i));
      if (i == DEPTH - 1) begin
        checks++;
        if (full !== 1'b0) begin
          failures++;
          $display("FAIL full_early: got full=%b after 15 writes, expected 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full_set: got full=%b, expected 1", full);
    end
    write_elem(8'd99);
    checks++;
    if (full !== 1'b1) begin
      failures++;
      $display("FAIL full_hold: got full=%b after dropped write, expected 1", full);
    end
    pulse_start();
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (valid_out) last_v = i;
      if (done) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_done: no done within 80 cycles, expected done");
    end
    bubble_total += (last_v + 1) - DEPTH;
    checks++;
    if (vout_cnt != DEPTH || exp_q.size() != 0 || result !== 10'd38 || full !== 1'b0) begin
      failures++;
      $display("FAIL full_stream: got n=%0d left=%0d result=%0d full=%b, expected 16/0/38/0",
               vout_cnt, exp_q.size(), result, full);
    end
    tb_count = 0;
  endtask

  task automatic test_timeout();
    int last_v = -1, err_at = -1, d0, ok;
    model_en = 1'b0;
    write_elem(8'd5);
    write_elem(8'd6);
    write_elem(8'd7);
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (valid_out) last_v = i;
      if (err) begin err_at = i; break; end
    end
    checks++;
    if (err_at < 0 || err_at - last_v != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_delay: got err %0d cycles after last valid, expected %0d",
               err_at - last_v, TIMEOUT);
    end
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL timeout_state: got busy=%b done_pulses=%0d, expected 0/0", busy, done_cnt - d0);
    end
    // Restart: only the err clear and completion matter here, not the data.
    mon_en    = 1'b0;
    model_en  = 1'b1;
    model_sum = 0;
    tb_count  = 0;
    write_elem(8'd3);
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: got err=%b after new start, expected 0", err);
    end
    wait_done(40, "timeout_restart", ok);
    exp_q.delete();
    tick();
    tick();
    mon_en   = 1'b1;
    tb_count = 0;
  endtask

  task automatic test_reset_mid_send();
    int ok = 0;
    model_sum = 0;
    vout_cnt  = 0;
    for (int i = 0; i < 8; i++) write_elem(8'(10 + i));
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (vout_cnt >= 3) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset_wait: got %0d elements, expected 3", vout_cnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_stop: got valid_out=%b busy=%b, expected 0/0", valid_out, busy);
    end
    reset = 1'b0;
    exp_q.delete();
    tb_count = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (full !== 1'b0 || result !== 10'd0) begin
      failures++;
      $display("FAIL midreset_state: got full=%b result=%0d, expected 0/0", full, result);
    end
    pulse_start();
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || valid_out) ok = 1;
      tick();
    end
    checks++;
    if (ok != 0) begin
      failures++;
      $display("FAIL midreset_start: got activity after start, expected none");
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_empty_start();
    test_full();
    test_timeout();
    test_reset_mid_send();
`ifdef L2_BUBBLE_EN
    checks++;
    if (bubble_total < 1) begin
      failures++;
      $display("FAIL bubble_seen: got %0d bubble cycles, expected at least 1", bubble_total);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_vec_sender.md
Name: l2_vec_sender

Overview:
- Stimulus/transmit end of the L2-norm streaming interface.
- Buffers a vector of 8-bit elements and streams them out as an element/valid stream. Each element is accepted by the norm unit on a cycle where its valid input is high.
- Collects the returning norm/valid stream, latches the final norm and signals completion.
- Used as the on-chip source and collector in front of the running-norm datapath.

Parameters:
- DEPTH, 16, element buffer entries; power of two, at least 2.
- TIMEOUT, 8, cycles allowed after the last element for all results to return.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_data  in  8  element to buffer.
- full  out  1  buffer holds DEPTH elements.
- start  in  1  one-cycle request to stream the buffered vector.
- busy  out  1  streaming or draining.
- a  out  8  element to norm unit.
- valid_out  out  1  a is valid this cycle; drives the norm unit's valid_in.
- g  in  10  norm returned by the norm unit.
- valid_in  in  1  g is valid this cycle; driven by the norm unit's valid_out.
- result  out  10  last norm received.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; count, wr_ptr, rd_ptr, sent and rcvd all 0. Buffer contents are don't care.
- All outputs are registered.
- States: IDLE, SEND, DRAIN. The done pulse is issued on the DRAIN->IDLE transition.

IDLE:
- wr_en with count<DEPTH writes buf[wr_ptr], then wr_ptr++ and count++.
- wr_en while full is dropped, with no side effects.
- start with count>0 goes to SEND and clears rd_ptr, sent, rcvd and err.
- start with count==0 is ignored.
- If wr_en and start occur in the same cycle, the write lands first and start sees the updated count.

SEND:
- start is sampled at edge N. The first valid_out=1 is visible after edge N+1.
- Each enabled cycle: a<=buf[rd_ptr], valid_out<=1, rd_ptr++, sent++.
- Elements are issued in write order and back-to-back unless the optional feature inserts bubbles.
- After the element with sent==count has been issued, go to DRAIN and load the timeout counter with TIMEOUT.
- wr_en and start are ignored while busy.

DRAIN:
- valid_out=0; a holds its last value.
- Each valid_in: result<=g, rcvd++, and the timeout counter reloads.
- When rcvd==count: done=1 for one cycle, count and wr_ptr are cleared, go to IDLE.
- If the timeout counter reaches 0 first: err<=1, count is cleared, go to IDLE, no done pulse.

Return path:
- valid_in is also accepted during SEND, because results can return while elements are still in flight.
- valid_in received in IDLE is ignored; result is not updated.

Other rules:
- busy=1 in SEND and DRAIN.
- full is (count==DEPTH), registered together with count.
- Pointers use log2(DEPTH) bits; count uses log2(DEPTH)+1 bits. Pointer wrap cannot occur within one vector.
- A reset asserted during SEND or DRAIN has the reset effect at the next edge: valid_out=0 and the buffer is emptied. Any partial vector is abandoned.

Optional Feature:
- Macro: L2_BUBBLE_EN.
- Defined:
  - An 8-bit maximal-length LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and steps every cycle.
  - In SEND, a cycle with lfsr[0]==1 is a bubble: valid_out=0, a holds, and rd_ptr and sent do not advance.
  - Element order and the final result are unchanged.
  - The timeout is not armed until the last element has been issued.
- Not defined: no LFSR; SEND issues one element per cycle.

Test Plan:
- Happy path (bench norm model, 2-cycle latency, running sqrt of sum of squares):
  - Write 21, 36, 64, then pulse start.
  - a = 21, 36, 64 on three consecutive valid_out cycles.
  - Returned g = 21, 41, 76; result=76; done pulses once; busy drops the same cycle; full=0; err=0.
- Empty start: pulse start with count==0 -> busy, valid_out and done stay 0 for 10 cycles.
- Full buffer: write 16 values (1..16), then a 17th (99) -> full=1 after the 16th write.
  - Stream order is 1..16 and 99 never appears.
- Timeout: model never returns valid_in -> err=1 exactly TIMEOUT cycles after the last valid_out; no done; busy=0.
  - A new start then clears err.
- Reset mid-SEND: 8 elements loaded, reset asserted after the 3rd valid_out -> valid_out=0 next cycle.
  - After reset: full=0 and result=0; a subsequent start is ignored.
- With L2_BUBBLE_EN: same vector as the happy path -> at least one bubble cycle appears; element order is unchanged; result=76; done=1.
